id_ex_stage: RTL and testbench

- ID→EX pipeline stage of the pipelined MIPS datapath. Consumes the decoder's control bits (RegDst, Jump, BranchEq, BranchNeq, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp) plus ID operands, and registers them into the ID/EX latch.
- Contains hazard detection for load-use and ID-resolved branches. On a hazard it stalls PC and IF/ID and inserts a bubble into EX.

---
 rtl/id_ex_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID->EX pipeline latch of the pipelined MIPS datapath, together with the
// hazard unit that protects it. The latch carries the decoder control bits and
// the ID operands into EX with one cycle of latency. The hazard unit detects
// three cases:
//   * load-use: a load sitting in EX writes a register the ID instruction reads
//   * branch after an ALU op: an ID-resolved branch reads a register still
//     being produced in EX
//   * branch after a load: an ID-resolved branch reads a register that a load
//     in MEM is still fetching
// On a hazard the PC and IF/ID are held and a bubble (all controls zero) is
// inserted into EX. An ID flush also inserts a bubble but never stalls.
//
// Build option:
//   HAZARD_STATS_EN - when defined, adds the free-running hazard counters
//                     load_use_cnt and br_stall_cnt.
//
// Parameters:
//   DW - datapath width (PC+4, register data, immediate)
//   RW - register-index width
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   id_<ctl> (x9), id_ALUOp decoder control bits for the ID instruction
//   id_pc4, id_rdata1,
//   id_rdata2, id_imm       ID data operands
//   id_rs, id_rt, id_rd,
//   id_funct                ID instruction fields
//   id_flush                kill the ID instruction (bubble into EX)
//   mem_MemRead, mem_dest   load flag and destination of the MEM instruction
//   ex_<ctl> (x9), ex_ALUOp registered control bits
//   ex_pc4 .. ex_funct      registered data and fields
//   ex_dest                 registered destination (rd for R-type, else rt)
//   stall                   combinational hazard indication
//   pc_write, ifid_write    write enables for PC and IF/ID (= ~stall)
//   load_use_cnt,
//   br_stall_cnt            hazard counters (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   // decoder control bits
   input  logic          id_RegDst,
   input  logic          id_Jump,
   input  logic          id_BranchEq,
   input  logic          id_BranchNeq,
   input  logic          id_MemRead,
   input  logic          id_MemtoReg,
   input  logic          id_MemWrite,
   input  logic          id_ALUSrc,
   input  logic          id_RegWrite,
   input  logic [1:0]    id_ALUOp,
   // ID operands and fields
   input  logic [DW-1:0] id_pc4,
   input  logic [DW-1:0] id_rdata1,
   input  logic [DW-1:0] id_rdata2,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [5:0]    id_funct,
   input  logic          id_flush,
   // MEM-stage information for branch-after-load detection
   input  logic          mem_MemRead,
   input  logic [RW-1:0] mem_dest,
   // registered control bits
   output logic          ex_RegDst,
   output logic          ex_Jump,
   output logic          ex_BranchEq,
   output logic          ex_BranchNeq,
   output logic          ex_MemRead,
   output logic          ex_MemtoReg,
   output logic          ex_MemWrite,
   output logic          ex_ALUSrc,
   output logic          ex_RegWrite,
   output logic [1:0]    ex_ALUOp,
   // registered data and fields
   output logic [DW-1:0] ex_pc4,
   output logic [DW-1:0] ex_rdata1,
   output logic [DW-1:0] ex_rdata2,
   output logic [DW-1:0] ex_imm,
   output logic [RW-1:0] ex_rs,
   output logic [RW-1:0] ex_rt,
   output logic [RW-1:0] ex_rd,
   output logic [5:0]    ex_funct,
   output logic [RW-1:0] ex_dest,
   // hazard control
   output logic          stall,
   output logic          pc_write,
   output logic          ifid_write
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]   load_use_cnt,
   output logic [31:0]   br_stall_cnt
`endif
);

   // A producer register matches a consumer register only when it is a real
   // destination; register 0 is hardwired and never creates a dependency.
   function automatic logic reg_match(input logic [RW-1:0] dest,
                                      input logic [RW-1:0] src);
      return (dest != '0) && (dest == src);
   endfunction

   logic          uses_rt;
   logic          is_br;
   logic          load_use;
   logic          br_alu;
   logic          br_load;
   logic          bubble;
   logic [RW-1:0] id_dest;

   // rt counts as a source whenever the ALU's second operand is a register or
   // the instruction is a store. This over-approximates (j is included), which
   // can only cost an extra stall, never a missed one.
   assign uses_rt = ~id_ALUSrc | id_MemWrite;
   assign is_br   = id_BranchEq | id_BranchNeq;

   assign load_use = ex_MemRead &
                     (reg_match(ex_dest, id_rs) | (uses_rt & reg_match(ex_dest, id_rt)));

   // Loads in EX are already covered by load_use; this term handles ALU
   // producers only, whose result is forwardable one cycle later.
   assign br_alu = is_br & ex_RegWrite & ~ex_MemRead &
                   (reg_match(ex_dest, id_rs) | reg_match(ex_dest, id_rt));

   // Second stall cycle of a branch after a load: the load has moved to MEM
   // but its data is not available to the ID comparator until WB.
   assign br_load = is_br & mem_MemRead &
                    (reg_match(mem_dest, id_rs) | reg_match(mem_dest, id_rt));

   // A flushed instruction is dead, so holding it in ID would be pointless.
   assign stall      = (load_use | br_alu | br_load) & ~id_flush;
   assign pc_write   = ~stall;
   assign ifid_write = ~stall;
   assign bubble     = stall | id_flush;

   assign id_dest = id_RegDst ? id_rd : id_rt;

   // ID -> EX boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_RegDst    <= 1'b0;
         ex_Jump      <= 1'b0;
         ex_BranchEq  <= 1'b0;
         ex_BranchNeq <= 1'b0;
         ex_MemRead   <= 1'b0;
         ex_MemtoReg  <= 1'b0;
         ex_MemWrite  <= 1'b0;
         ex_ALUSrc    <= 1'b0;
         ex_RegWrite  <= 1'b0;
         ex_ALUOp     <= 2'b00;
         ex_dest      <= '0;
         ex_pc4       <= '0;
         ex_rdata1    <= '0;
         ex_rdata2    <= '0;
         ex_imm       <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_rd        <= '0;
         ex_funct     <= '0;
      end else begin
         // Data and fields are captured unconditionally; a bubble is made
         // harmless by its all-zero controls and zero destination alone.
         ex_pc4    <= id_pc4;
         ex_rdata1 <= id_rdata1;
         ex_rdata2 <= id_rdata2;
         ex_imm    <= id_imm;
         ex_rs     <= id_rs;
         ex_rt     <= id_rt;
         ex_rd     <= id_rd;
         ex_funct  <= id_funct;
         if (bubble) begin
            ex_RegDst    <= 1'b0;
            ex_Jump      <= 1'b0;
            ex_BranchEq  <= 1'b0;
            ex_BranchNeq <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemtoReg  <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_ALUOp     <= 2'b00;
            ex_dest      <= '0;
         end else begin
            ex_RegDst    <= id_RegDst;
            ex_Jump      <= id_Jump;
            ex_BranchEq  <= id_BranchEq;
            ex_BranchNeq <= id_BranchNeq;
            ex_MemRead   <= id_MemRead;
            ex_MemtoReg  <= id_MemtoReg;
            ex_MemWrite  <= id_MemWrite;
            ex_ALUSrc    <= id_ALUSrc;
            ex_RegWrite  <= id_RegWrite;
            ex_ALUOp     <= id_ALUOp;
            ex_dest      <= id_dest;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   // A cycle where load_use and a branch hazard coincide is attributed to the
   // load, so every stall cycle lands in exactly one counter. Both counters
   // wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_use_cnt <= '0;
         br_stall_cnt <= '0;
      end else begin
         if (load_use & stall)
            load_use_cnt <= load_use_cnt + 32'd1;
         if ((br_alu | br_load) & stall & ~load_use)
            br_stall_cnt <= br_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed, table-driven bench for id_ex_stage. Each table row is one ID cycle:
// the inputs, the expected combinational stall for that cycle, and the expected
// EX controls / destination after the following rising edge. Rows run in order,
// so each row's stall expectation depends on what the previous row latched.
// With HAZARD_STATS_EN defined, a short extra sequence covers the counters.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   // control packing: {RegDst,Jump,BrEq,BrNeq,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp[1:0]}
   localparam logic [10:0] C_R    = 11'h406;
   localparam logic [10:0] C_LW   = 11'h06C;
   localparam logic [10:0] C_ADDI = 11'h00C;
   localparam logic [10:0] C_SW   = 11'h018;
   localparam logic [10:0] C_BEQ  = 11'h101;
   localparam logic [10:0] C_J    = 11'h200;
   localparam logic [10:0] C_RND  = 11'h7FF;

   typedef struct {
      logic          rst;
      logic [10:0]   ctl;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] rd;
      logic [DW-1:0] rdata1;
      logic          flush;
      logic          mem_rd;
      logic [RW-1:0] mem_dst;
      logic          chk_stall;
      logic          exp_stall;
      logic [10:0]   exp_ctl;
      logic [RW-1:0] exp_dest;
      logic          chk_data;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_RegDst, id_Jump, id_BranchEq, id_BranchNeq, id_MemRead;
   logic          id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
   logic [1:0]    id_ALUOp;
   logic [DW-1:0] id_pc4, id_rdata1, id_rdata2, id_imm;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic [5:0]    id_funct;
   logic          id_flush;
   logic          mem_MemRead;
   logic [RW-1:0] mem_dest;
   logic          ex_RegDst, ex_Jump, ex_BranchEq, ex_BranchNeq, ex_MemRead;
   logic          ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
   logic [1:0]    ex_ALUOp;
   logic [DW-1:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
   logic [RW-1:0] ex_rs, ex_rt, ex_rd, ex_dest;
   logic [5:0]    ex_funct;
   logic          stall, pc_write, ifid_write;
`ifdef HAZARD_STATS_EN
   logic [31:0]   load_use_cnt, br_stall_cnt;
`endif
   logic [10:0]   ex_ctl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign ex_ctl = {ex_RegDst, ex_Jump, ex_BranchEq, ex_BranchNeq, ex_MemRead,
                    ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp};

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .reset(reset),
      .id_RegDst(id_RegDst), .id_Jump(id_Jump), .id_BranchEq(id_BranchEq),
      .id_BranchNeq(id_BranchNeq), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
      .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
      .id_ALUOp(id_ALUOp),
      .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
      .id_flush(id_flush), .mem_MemRead(mem_MemRead), .mem_dest(mem_dest),
      .ex_RegDst(ex_RegDst), .ex_Jump(ex_Jump), .ex_BranchEq(ex_BranchEq),
      .ex_BranchNeq(ex_BranchNeq), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
      .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
      .ex_ALUOp(ex_ALUOp),
      .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
      .ex_dest(ex_dest),
      .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef HAZARD_STATS_EN
      ,
      .load_use_cnt(load_use_cnt), .br_stall_cnt(br_stall_cnt)
`endif
   );

   function automatic vec_t v(input logic rst, input logic [10:0] ctl,
                              input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                              input logic [RW-1:0] rd, input logic [DW-1:0] rdata1,
                              input logic flush, input logic mem_rd,
                              input logic [RW-1:0] mem_dst, input logic chk_stall,
                              input logic exp_stall, input logic [10:0] exp_ctl,
                              input logic [RW-1:0] exp_dest, input logic chk_data);
      vec_t r;
      r.rst = rst;             r.ctl = ctl;
      r.rs = rs;               r.rt = rt;             r.rd = rd;
      r.rdata1 = rdata1;       r.flush = flush;
      r.mem_rd = mem_rd;       r.mem_dst = mem_dst;
      r.chk_stall = chk_stall; r.exp_stall = exp_stall;
      r.exp_ctl = exp_ctl;     r.exp_dest = exp_dest; r.chk_data = chk_data;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one row at the falling edge, check the combinational stall before
   // the rising edge, then check the latched EX state just after it.
   task automatic step(input vec_t r, input string tag);
      @(negedge clk);
      reset       = r.rst;
      {id_RegDst, id_Jump, id_BranchEq, id_BranchNeq, id_MemRead,
       id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp} = r.ctl;
      id_rs       = r.rs;
      id_rt       = r.rt;
      id_rd       = r.rd;
      id_rdata1   = r.rdata1;
      id_rdata2   = ~r.rdata1;
      id_pc4      = r.rdata1 + 32'd4;
      id_imm      = {27'd0, r.rd};
      id_funct    = 6'h20;
      id_flush    = r.flush;
      mem_MemRead = r.mem_rd;
      mem_dest    = r.mem_dst;
      #1;
      if (r.chk_stall) begin
         check({tag, "_stall"},      {31'd0, stall},      {31'd0, r.exp_stall});
         check({tag, "_pc_write"},   {31'd0, pc_write},   {31'd0, ~r.exp_stall});
         check({tag, "_ifid_write"}, {31'd0, ifid_write}, {31'd0, ~r.exp_stall});
      end
      @(posedge clk);
      #1;
      check({tag, "_ex_ctl"},  {21'd0, ex_ctl},  {21'd0, r.exp_ctl});
      check({tag, "_ex_dest"}, {27'd0, ex_dest}, {27'd0, r.exp_dest});
      if (r.chk_data) begin
         check({tag, "_ex_rdata1"}, ex_rdata1, r.rdata1);
         check({tag, "_ex_rd"},     {27'd0, ex_rd}, {27'd0, r.rd});
      end
   endtask

   vec_t tbl[$];
`ifdef HAZARD_STATS_EN
   vec_t stats[$];
`endif

   initial begin
      // reset with arbitrary inputs (first row: pre-reset state is unknown)
      tbl.push_back(v(1, C_RND, 8, 8, 9, 32'hDEADBEEF, 0, 0, 8, 0, 0, 11'h0, 0, 0));
      tbl.push_back(v(1, C_RND, 8, 8, 9, 32'hA5A5A5A5, 0, 0, 8, 1, 0, 11'h0, 0, 0));
      // R-type pass-through
      tbl.push_back(v(0, C_R,    1, 8,  9, 32'h1234, 0, 0, 0, 1, 0, C_R,    9, 1));
      // load-use: lw rt=8 then add rs=8
      tbl.push_back(v(0, C_LW,   2, 8,  3, 32'h11,   0, 0, 0, 1, 0, C_LW,   8, 1));
      tbl.push_back(v(0, C_R,    8, 4, 10, 32'h22,   0, 0, 0, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_R,    8, 4, 10, 32'h22,   0, 0, 0, 1, 0, C_R,   10, 1));
      // addi rt=8 after lw rt=8: rt is not a source
      tbl.push_back(v(0, C_LW,   2, 8,  3, 32'h33,   0, 0, 0, 1, 0, C_LW,   8, 1));
      tbl.push_back(v(0, C_ADDI, 3, 8,  0, 32'h44,   0, 0, 0, 1, 0, C_ADDI, 8, 1));
      // sw rt=8 after lw rt=8: store data is a source
      tbl.push_back(v(0, C_LW,   2, 8,  3, 32'h55,   0, 0, 0, 1, 0, C_LW,   8, 1));
      tbl.push_back(v(0, C_SW,   3, 8,  0, 32'h66,   0, 0, 0, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_SW,   3, 8,  0, 32'h66,   0, 0, 0, 1, 0, C_SW,   8, 1));
      // beq after add rd=5: one stall
      tbl.push_back(v(0, C_R,    1, 2,  5, 32'h77,   0, 0, 0, 1, 0, C_R,    5, 1));
      tbl.push_back(v(0, C_BEQ,  5, 6,  0, 32'h88,   0, 0, 0, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_BEQ,  5, 6,  0, 32'h88,   0, 0, 0, 1, 0, C_BEQ,  6, 1));
      // beq after lw rt=5: two stalls (load_use, then br_load)
      tbl.push_back(v(0, C_LW,   2, 5,  0, 32'h99,   0, 0, 0, 1, 0, C_LW,   5, 1));
      tbl.push_back(v(0, C_BEQ,  5, 6,  0, 32'hAA,   0, 0, 0, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_BEQ,  5, 6,  0, 32'hAA,   0, 1, 5, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_BEQ,  5, 6,  0, 32'hAA,   0, 0, 0, 1, 0, C_BEQ,  6, 1));
      // register 0 never causes a hazard
      tbl.push_back(v(0, C_LW,   2, 0,  0, 32'hBB,   0, 0, 0, 1, 0, C_LW,   0, 1));
      tbl.push_back(v(0, C_R,    0, 0,  7, 32'hCC,   0, 0, 0, 1, 0, C_R,    7, 1));
      tbl.push_back(v(0, C_R,    0, 0,  0, 32'hDD,   0, 0, 0, 1, 0, C_R,    0, 1));
      tbl.push_back(v(0, C_BEQ,  0, 0,  0, 32'hEE,   0, 1, 0, 1, 0, C_BEQ,  0, 1));
      // flush overrides a load-use stall
      tbl.push_back(v(0, C_LW,   2, 8,  3, 32'h101,  0, 0, 0, 1, 0, C_LW,   8, 1));
      tbl.push_back(v(0, C_R,    8, 1, 11, 32'h102,  1, 0, 0, 1, 0, 11'h0,  0, 0));
      tbl.push_back(v(0, C_R,    8, 1, 11, 32'h102,  0, 0, 0, 1, 0, C_R,   11, 1));
      // load_use and br_load together: one stall, then br_load alone
      tbl.push_back(v(0, C_LW,   2, 4,  0, 32'h103,  0, 0, 0, 1, 0, C_LW,   4, 1));
      tbl.push_back(v(0, C_BEQ,  4, 6,  0, 32'h104,  0, 1, 6, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_BEQ,  4, 6,  0, 32'h104,  0, 1, 4, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_BEQ,  4, 6,  0, 32'h104,  0, 0, 0, 1, 0, C_BEQ,  6, 1));
      // reset during a stall, next cycle stall-free
      tbl.push_back(v(0, C_LW,   2, 8,  3, 32'h105,  0, 0, 0, 1, 0, C_LW,   8, 1));
      tbl.push_back(v(1, C_R,    8, 1, 12, 32'h106,  0, 0, 0, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_R,    8, 1, 12, 32'h106,  0, 0, 0, 1, 0, C_R,   12, 1));
      // j reads rt conservatively
      tbl.push_back(v(0, C_LW,   2, 8,  3, 32'h107,  0, 0, 0, 1, 0, C_LW,   8, 1));
      tbl.push_back(v(0, C_J,    0, 8,  0, 32'h108,  0, 0, 0, 1, 1, 11'h0,  0, 0));
      tbl.push_back(v(0, C_J,    0, 8,  0, 32'h108,  0, 0, 0, 1, 0, C_J,    8, 1));

      reset = 1'b1;
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i], $sformatf("row%0d", i));

`ifdef HAZARD_STATS_EN
      // lw -> add (load-use), then add -> beq (branch after ALU)
      stats.push_back(v(1, C_R,    0, 0,  0, 32'h0,  0, 0, 0, 1, 0, 11'h0,  0, 0));
      stats.push_back(v(0, C_LW,   2, 8,  3, 32'h1,  0, 0, 0, 1, 0, C_LW,   8, 0));
      stats.push_back(v(0, C_R,    8, 1, 11, 32'h2,  0, 0, 0, 1, 1, 11'h0,  0, 0));
      stats.push_back(v(0, C_R,    8, 1, 11, 32'h2,  0, 0, 0, 1, 0, C_R,   11, 0));
      stats.push_back(v(0, C_BEQ, 11, 6,  0, 32'h3,  0, 0, 0, 1, 1, 11'h0,  0, 0));
      stats.push_back(v(0, C_BEQ, 11, 6,  0, 32'h3,  0, 0, 0, 1, 0, C_BEQ,  6, 0));
      for (int i = 0; i < stats.size(); i++)
         step(stats[i], $sformatf("stats%0d", i));
      check("load_use_cnt", load_use_cnt, 32'd1);
      check("br_stall_cnt", br_stall_cnt, 32'd1);

      // wrap: preload the load-use counter to all ones, then one more load-use
      force dut.load_use_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.load_use_cnt;
      step(v(0, C_LW, 2, 8, 3, 32'h4, 0, 0, 0, 1, 0, C_LW, 8, 0), "wrap0");
      check("load_use_cnt_preload", load_use_cnt, 32'hFFFF_FFFF);
      step(v(0, C_R, 8, 1, 11, 32'h5, 0, 0, 0, 1, 1, 11'h0, 0, 0), "wrap1");
      check("load_use_cnt_wrap", load_use_cnt, 32'd0);
      check("br_stall_cnt_hold", br_stall_cnt, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
